// File: rtl/ysyx_22051086_axi_arbiter.sv
// Two-master (ICACHE, DCACHE) to one-slave AXI4-Lite arbiter.
// One transaction outstanding at a time; round-robin between I and D.
module ysyx_22051086_axi_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   // ICACHE read
   input  logic [ADDR_W-1:0]     i_araddr,
   input  logic                  i_arvalid,
   output logic                  i_arready,
   output logic [DATA_W-1:0]     i_rdata,
   output logic [1:0]            i_rresp,
   output logic                  i_rvalid,
   input  logic                  i_rready,
   // DCACHE read
   input  logic [ADDR_W-1:0]     d_araddr,
   input  logic                  d_arvalid,
   output logic                  d_arready,
   output logic [DATA_W-1:0]     d_rdata,
   output logic [1:0]            d_rresp,
   output logic                  d_rvalid,
   input  logic                  d_rready,
   // DCACHE write
   input  logic [ADDR_W-1:0]     d_awaddr,
   input  logic                  d_awvalid,
   output logic                  d_awready,
   input  logic [DATA_W-1:0]     d_wdata,
   input  logic [DATA_W/8-1:0]   d_wstrb,
   input  logic                  d_wvalid,
   output logic                  d_wready,
   output logic [1:0]            d_bresp,
   output logic                  d_bvalid,
   input  logic                  d_bready,
   // memory side
   output logic [ADDR_W-1:0]     m_araddr,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   input  logic [DATA_W-1:0]     m_rdata,
   input  logic [1:0]            m_rresp,
   input  logic                  m_rvalid,
   output logic                  m_rready,
   output logic [ADDR_W-1:0]     m_awaddr,
   output logic                  m_awvalid,
   input  logic                  m_awready,
   output logic [DATA_W-1:0]     m_wdata,
   output logic [DATA_W/8-1:0]   m_wstrb,
   output logic                  m_wvalid,
   input  logic                  m_wready,
   input  logic [1:0]            m_bresp,
   input  logic                  m_bvalid,
   output logic                  m_bready
);

   typedef enum logic [2:0] {IDLE, I_AR, I_R, D_AR, D_R, D_W, D_B} state_t;

   state_t               state, state_nxt;
   logic                 last_grant, last_grant_nxt;
   logic                 aw_done, aw_done_nxt, w_done, w_done_nxt;
   logic [ADDR_W-1:0]    arb_addr;
   logic [DATA_W-1:0]    arb_wdata;
   logic [DATA_W/8-1:0]  arb_wstrb;
   logic                 grant_i, grant_dr, grant_dw;
   logic                 d_wreq, d_req, aw_fin, w_fin;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         arb_addr   <= '0;
         arb_wdata  <= '0;
         arb_wstrb  <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         aw_done    <= aw_done_nxt;
         w_done     <= w_done_nxt;
         if (grant_i)
            arb_addr <= i_araddr;
         else if (grant_dw) begin
            arb_addr  <= d_awaddr;
            arb_wdata <= d_wdata;
            arb_wstrb <= d_wstrb;
         end else if (grant_dr)
            arb_addr <= d_araddr;
      end
   end

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      aw_done_nxt    = aw_done;
      w_done_nxt     = w_done;
      grant_i        = 1'b0;
      grant_dr       = 1'b0;
      grant_dw       = 1'b0;
      aw_fin         = 1'b0;
      w_fin          = 1'b0;
      d_wreq         = d_awvalid && d_wvalid;
      d_req          = d_wreq || d_arvalid;
      i_arready = 1'b0; i_rdata = '0; i_rresp = '0; i_rvalid = 1'b0;
      d_arready = 1'b0; d_rdata = '0; d_rresp = '0; d_rvalid = 1'b0;
      d_awready = 1'b0; d_wready = 1'b0; d_bresp = '0; d_bvalid = 1'b0;
      m_araddr  = '0; m_arvalid = 1'b0; m_rready = 1'b0;
      m_awaddr  = '0; m_awvalid = 1'b0;
      m_wdata   = '0; m_wstrb = '0; m_wvalid = 1'b0;
      m_bready  = 1'b0;

      case (state)
         IDLE: begin
            // last_grant=0 favours I on contention; set to 1 after an I grant
            if (!rst) begin
               if (i_arvalid && (!d_req || !last_grant)) grant_i = 1'b1;
               else if (d_wreq)                          grant_dw = 1'b1;
               else if (d_arvalid)                       grant_dr = 1'b1;
            end
            i_arready = grant_i;
            d_awready = grant_dw;
            d_wready  = grant_dw;
            d_arready = grant_dr;
            if (grant_i) begin
               state_nxt      = I_AR;
               last_grant_nxt = 1'b1;
            end else if (grant_dw) begin
               state_nxt      = D_W;
               last_grant_nxt = 1'b0;
            end else if (grant_dr) begin
               state_nxt      = D_AR;
               last_grant_nxt = 1'b0;
            end
         end
         I_AR, D_AR: begin
            m_arvalid = 1'b1;
            m_araddr  = arb_addr;
            if (m_arready) state_nxt = (state == I_AR) ? I_R : D_R;
         end
         I_R: begin
            m_rready = i_rready;
            i_rvalid = m_rvalid;
            i_rdata  = m_rdata;
            i_rresp  = m_rresp;
            if (m_rvalid && i_rready) state_nxt = IDLE;
         end
         D_R: begin
            m_rready = d_rready;
            d_rvalid = m_rvalid;
            d_rdata  = m_rdata;
            d_rresp  = m_rresp;
            if (m_rvalid && d_rready) state_nxt = IDLE;
         end
         D_W: begin
            m_awvalid = !aw_done;
            m_awaddr  = arb_addr;
            m_wvalid  = !w_done;
            m_wdata   = arb_wdata;
            m_wstrb   = arb_wstrb;
            // AW and W may complete in either order or together
            aw_fin    = aw_done || m_awready;
            w_fin     = w_done || m_wready;
            if (aw_fin && w_fin) begin
               state_nxt   = D_B;
               aw_done_nxt = 1'b0;
               w_done_nxt  = 1'b0;
            end else begin
               aw_done_nxt = aw_fin;
               w_done_nxt  = w_fin;
            end
         end
         D_B: begin
            d_bvalid = m_bvalid;
            d_bresp  = m_bresp;
            m_bready = d_bready;
            if (m_bvalid && d_bready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ysyx_22051086_axi_arbiter.sv
// Bench for the I/D AXI arbiter: memory model, scoreboard of expected
// transactions in grant order, and per-scenario directed tasks.
`timescale 1ns/1ps
module tb_ysyx_22051086_axi_arbiter;
   localparam int AW = 32;
   localparam int DW = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [AW-1:0] i_araddr = '0, d_araddr = '0, d_awaddr = '0;
   logic i_arvalid = 0, i_arready, i_rvalid, i_rready = 1;
   logic [DW-1:0] i_rdata, d_rdata;
   logic [1:0] i_rresp, d_rresp, d_bresp;
   logic d_arvalid = 0, d_arready, d_rvalid, d_rready = 1;
   logic d_awvalid = 0, d_awready, d_wvalid = 0, d_wready, d_bvalid, d_bready = 1;
   logic [DW-1:0] d_wdata = '0;
   logic [DW/8-1:0] d_wstrb = '0;
   logic [AW-1:0] m_araddr, m_awaddr;
   logic m_arvalid, m_arready = 0, m_rvalid = 0, m_rready;
   logic [DW-1:0] m_rdata = '0, m_wdata;
   logic [1:0] m_rresp = '0, m_bresp = '0;
   logic m_awvalid, m_awready = 0, m_wvalid, m_wready = 0, m_bvalid = 0, m_bready;
   logic [DW/8-1:0] m_wstrb;

   always #5 clk = ~clk;

   ysyx_22051086_axi_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .i_araddr(i_araddr), .i_arvalid(i_arvalid), .i_arready(i_arready),
      .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .i_rready(i_rready),
      .d_araddr(d_araddr), .d_arvalid(d_arvalid), .d_arready(d_arready),
      .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rvalid(d_rvalid), .d_rready(d_rready),
      .d_awaddr(d_awaddr), .d_awvalid(d_awvalid), .d_awready(d_awready),
      .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wvalid(d_wvalid), .d_wready(d_wready),
      .d_bresp(d_bresp), .d_bvalid(d_bvalid), .d_bready(d_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
   );

   // kind: 0 = I read, 1 = D read, 2 = D write
   typedef struct {
      int        kind;
      logic [31:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
   } txn_t;

   txn_t exp_q[$];
   txn_t cur;
   int errors = 0, checks = 0, done_cnt = 0;
   int r_wait = 0, aw_wait = 0, w_wait = 0;

   function automatic logic [63:0] mem_rd(input logic [31:0] a);
      return {a ^ 32'h80000013, a ^ 32'h80100093};
   endfunction

   // Handshakes resolved on the falling edge, consumed by the memory model
   logic s_ar_hs = 0, s_r_hs = 0, s_aw_hs = 0, s_w_hs = 0, s_b_hs = 0;
   logic [31:0] s_ar_addr = '0;

   always @(negedge clk) begin
      s_ar_hs = m_arvalid && m_arready;
      s_r_hs  = m_rvalid && m_rready;
      s_aw_hs = m_awvalid && m_awready;
      s_w_hs  = m_wvalid && m_wready;
      s_b_hs  = m_bvalid && m_bready;
      if (s_ar_hs) s_ar_addr = m_araddr;
      if (!rst) begin
         if (s_ar_hs || s_aw_hs) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected_txn ar=%0d aw=%0d addr=%h", s_ar_hs, s_aw_hs,
                        s_ar_hs ? m_araddr : m_awaddr);
            end else begin
               cur = exp_q.pop_front();
               if (s_ar_hs && (cur.kind == 2 || m_araddr !== cur.addr)) begin
                  errors++;
                  $display("FAIL sb_ar_order got addr=%h required kind=%0d addr=%h",
                           m_araddr, cur.kind, cur.addr);
               end
               if (s_aw_hs && (cur.kind != 2 || m_awaddr !== cur.addr)) begin
                  errors++;
                  $display("FAIL sb_aw_order got addr=%h required kind=%0d addr=%h",
                           m_awaddr, cur.kind, cur.addr);
               end
            end
         end
         if (s_w_hs) begin
            checks++;
            if (cur.kind != 2 || m_wdata !== cur.data || m_wstrb !== cur.strb) begin
               errors++;
               $display("FAIL sb_wdata got %h/%h required %h/%h", m_wdata, m_wstrb, cur.data, cur.strb);
            end
         end
         if (i_rvalid && i_rready) begin
            checks++; done_cnt++;
            if (cur.kind != 0 || i_rdata !== cur.data || i_rresp !== 2'b00) begin
               errors++;
               $display("FAIL sb_i_rdata got %h kind=%0d required %h", i_rdata, cur.kind, cur.data);
            end
         end
         if (d_rvalid && d_rready) begin
            checks++; done_cnt++;
            if (cur.kind != 1 || d_rdata !== cur.data || d_rresp !== 2'b00) begin
               errors++;
               $display("FAIL sb_d_rdata got %h kind=%0d required %h", d_rdata, cur.kind, cur.data);
            end
         end
         if (d_bvalid && d_bready) begin
            checks++; done_cnt++;
            if (cur.kind != 2 || d_bresp !== 2'b00) begin
               errors++;
               $display("FAIL sb_bresp got %0d kind=%0d required 0", d_bresp, cur.kind);
            end
         end
      end
   end

   // Memory model, driven just after the rising edge
   logic rd_pend = 0, got_aw = 0, got_w = 0;
   int rd_cnt = 0, aw_cnt = 0, w_cnt = 0;
   always @(posedge clk) begin
      #1;
      if (rst) begin
         m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
         m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0;
         rd_pend = 0; got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0;
      end else begin
         if (s_r_hs) m_rvalid = 0;
         if (s_ar_hs) begin rd_pend = 1; rd_cnt = r_wait; end
         if (rd_pend) begin
            if (rd_cnt == 0) begin
               m_rvalid = 1; m_rdata = mem_rd(s_ar_addr); m_rresp = 2'b00; rd_pend = 0;
            end else rd_cnt--;
         end
         m_arready = m_arvalid;
         m_awready = m_awvalid && (aw_cnt >= aw_wait);
         if (m_awvalid) aw_cnt++; else aw_cnt = 0;
         m_wready = m_wvalid && (w_cnt >= w_wait);
         if (m_wvalid) w_cnt++; else w_cnt = 0;
         if (s_b_hs) m_bvalid = 0;
         if (s_aw_hs) got_aw = 1;
         if (s_w_hs) got_w = 1;
         if (got_aw && got_w) begin
            m_bvalid = 1; m_bresp = 2'b00; got_aw = 0; got_w = 0;
         end
      end
   end

   task automatic reset_dut();
      rst = 1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic wait_done(input int target, input string name);
      int n = 0;
      while (done_cnt < target && n < 200) begin n++; @(negedge clk); end
      checks++;
      if (done_cnt < target) begin
         errors++;
         $display("FAIL %s_timeout done=%0d required %0d", name, done_cnt, target);
      end
      @(posedge clk); #1;
   endtask

   task automatic i_read_wait(input logic [31:0] a);
      int n = 0;
      i_araddr = a; i_arvalid = 1;
      @(negedge clk);
      while (!i_arready && n < 100) begin n++; @(negedge clk); end
      if (!i_arready) begin errors++; checks++; $display("FAIL i_grant_timeout addr=%h", a); end
      @(posedge clk); #1 i_arvalid = 0;
      n = 0;
      @(negedge clk);
      while (!(i_rvalid && i_rready) && n < 100) begin n++; @(negedge clk); end
      if (!i_rvalid) begin errors++; checks++; $display("FAIL i_resp_timeout addr=%h", a); end
      @(posedge clk); #1;
   endtask

   task automatic d_read_wait(input logic [31:0] a);
      int n = 0;
      d_araddr = a; d_arvalid = 1;
      @(negedge clk);
      while (!d_arready && n < 100) begin n++; @(negedge clk); end
      if (!d_arready) begin errors++; checks++; $display("FAIL d_grant_timeout addr=%h", a); end
      @(posedge clk); #1 d_arvalid = 0;
      n = 0;
      @(negedge clk);
      while (!(d_rvalid && d_rready) && n < 100) begin n++; @(negedge clk); end
      if (!d_rvalid) begin errors++; checks++; $display("FAIL d_resp_timeout addr=%h", a); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (2) @(negedge clk);
      checks++;
      if ({i_arready, d_arready, d_awready, d_wready, m_arvalid, m_awvalid, m_wvalid,
           m_rready, m_bready, i_rvalid, d_rvalid, d_bvalid} !== 12'h0 ||
          m_araddr !== '0 || m_awaddr !== '0 || m_wdata !== '0) begin
         errors++;
         $display("FAIL reset_outputs got arv=%b araddr=%h required all 0", m_arvalid, m_araddr);
      end
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      checks++;
      if ({m_arvalid, m_awvalid, m_wvalid, i_arready, d_arready} !== 5'b0) begin
         errors++;
         $display("FAIL idle_after_reset got %b required 00000",
                  {m_arvalid, m_awvalid, m_wvalid, i_arready, d_arready});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_read();
      int base = done_cnt;
      r_wait = 2;
      exp_q.push_back('{kind: 0, addr: 32'h80000000, data: 64'h00000013_00100093, strb: 8'h0});
      i_araddr = 32'h80000000; i_arvalid = 1;
      @(negedge clk);
      checks++;
      if ({i_arready, m_arvalid} !== 2'b10) begin
         errors++; $display("FAIL single_cyc0 got rdy/arv=%b required 10", {i_arready, m_arvalid});
      end
      @(posedge clk); #1 i_arvalid = 0;
      @(negedge clk);
      checks++;
      if (i_arready !== 1'b0 || m_arvalid !== 1'b1 || m_araddr !== 32'h80000000) begin
         errors++; $display("FAIL single_cyc1 got rdy=%b arv=%b addr=%h required 0 1 80000000",
                            i_arready, m_arvalid, m_araddr);
      end
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (i_rvalid !== 1'b0 || m_rready !== 1'b1) begin
            errors++; $display("FAIL single_wait got rvalid=%b rready=%b required 0 1", i_rvalid, m_rready);
         end
      end
      @(negedge clk);
      checks++;
      if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== 64'h00000013_00100093) begin
         errors++; $display("FAIL single_resp got iv=%b dv=%b data=%h required 1 0 0000001300100093",
                            i_rvalid, d_rvalid, i_rdata);
      end
      @(negedge clk);
      checks++;
      if ({i_rvalid, m_arvalid, m_rready} !== 3'b000) begin
         errors++; $display("FAIL single_idle got %b required 000", {i_rvalid, m_arvalid, m_rready});
      end
      @(posedge clk); #1;
      wait_done(base + 1, "single");
   endtask

   task automatic test_simultaneous();
      int base, n;
      reset_dut();
      base = done_cnt; r_wait = 0;
      exp_q.push_back('{kind: 0, addr: 32'h80000010, data: mem_rd(32'h80000010), strb: 8'h0});
      exp_q.push_back('{kind: 1, addr: 32'h80001000, data: mem_rd(32'h80001000), strb: 8'h0});
      i_araddr = 32'h80000010; i_arvalid = 1;
      d_araddr = 32'h80001000; d_arvalid = 1;
      @(negedge clk);
      checks++;
      if ({i_arready, d_arready} !== 2'b10) begin
         errors++; $display("FAIL simul_first_grant got i/d=%b required 10", {i_arready, d_arready});
      end
      @(posedge clk); #1 i_arvalid = 0;
      n = 1;
      @(negedge clk);
      while (!d_arready && n < 50) begin n++; @(negedge clk); end
      checks++;
      if (n != 3) begin
         errors++; $display("FAIL simul_d_grant_cycle got %0d required 3", n);
      end
      @(posedge clk); #1 d_arvalid = 0;
      wait_done(base + 2, "simul");
   endtask

   task automatic test_contention();
      int base;
      reset_dut();
      base = done_cnt; r_wait = 1;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back('{kind: 0, addr: 32'h80000100 + 16*k, data: mem_rd(32'h80000100 + 16*k), strb: 8'h0});
         exp_q.push_back('{kind: 1, addr: 32'h80004000 + 16*k, data: mem_rd(32'h80004000 + 16*k), strb: 8'h0});
      end
      fork
         for (int k = 0; k < 4; k++) i_read_wait(32'h80000100 + 16*k);
         for (int j = 0; j < 4; j++) d_read_wait(32'h80004000 + 16*j);
      join
      checks++;
      if (done_cnt - base != 8 || exp_q.size() != 0) begin
         errors++; $display("FAIL contention_count got %0d left=%0d required 8 0", done_cnt - base, exp_q.size());
      end
   endtask

   task automatic test_write();
      int base;
      reset_dut();
      base = done_cnt; aw_wait = 0; w_wait = 2;
      exp_q.push_back('{kind: 2, addr: 32'h80002000, data: 64'hDEADBEEF_CAFEF00D, strb: 8'h0F});
      d_awaddr = 32'h80002000; d_wdata = 64'hDEADBEEF_CAFEF00D; d_wstrb = 8'h0F;
      d_awvalid = 1; d_wvalid = 1;
      @(negedge clk);
      checks++;
      if ({d_awready, d_wready, m_awvalid} !== 3'b110) begin
         errors++; $display("FAIL write_grant got %b required 110", {d_awready, d_wready, m_awvalid});
      end
      @(posedge clk); #1 d_awvalid = 0; d_wvalid = 0;
      @(negedge clk);
      checks++;
      if ({m_awvalid, m_wvalid, m_awready, m_wready} !== 4'b1110) begin
         errors++; $display("FAIL write_cyc1 got %b required 1110", {m_awvalid, m_wvalid, m_awready, m_wready});
      end
      repeat (2) begin
         @(negedge clk);
         checks++;
         if ({m_awvalid, m_wvalid, m_bready, d_bvalid} !== 4'b0100) begin
            errors++; $display("FAIL write_aw_held got %b required 0100",
                               {m_awvalid, m_wvalid, m_bready, d_bvalid});
         end
      end
      @(negedge clk);
      checks++;
      if ({m_wvalid, m_bready, d_bvalid} !== 3'b011 || d_bresp !== 2'b00) begin
         errors++; $display("FAIL write_b got %b bresp=%0d required 011 0", {m_wvalid, m_bready, d_bvalid}, d_bresp);
      end
      @(posedge clk); #1;
      wait_done(base + 1, "write");
      w_wait = 0;
   endtask

   task automatic test_write_then_read();
      int base, n, early;
      logic b_seen;
      reset_dut();
      base = done_cnt; r_wait = 0; w_wait = 0; early = 0; b_seen = 0; n = 0;
      exp_q.push_back('{kind: 2, addr: 32'h80002100, data: 64'h11223344_55667788, strb: 8'hFF});
      exp_q.push_back('{kind: 1, addr: 32'h80002100, data: mem_rd(32'h80002100), strb: 8'h0});
      d_awaddr = 32'h80002100; d_wdata = 64'h11223344_55667788; d_wstrb = 8'hFF;
      d_araddr = 32'h80002100;
      d_awvalid = 1; d_wvalid = 1; d_arvalid = 1;
      @(negedge clk);
      checks++;
      if ({d_awready, d_wready, d_arready} !== 3'b110) begin
         errors++; $display("FAIL wr_first got %b required 110", {d_awready, d_wready, d_arready});
      end
      @(posedge clk); #1 d_awvalid = 0; d_wvalid = 0;
      @(negedge clk);
      while (!d_arready && n < 50) begin
         if (d_bvalid && d_bready) b_seen = 1;
         if (m_arvalid && !b_seen) early++;
         n++; @(negedge clk);
      end
      checks++;
      if (!b_seen || early != 0 || !d_arready) begin
         errors++; $display("FAIL wr_before_rd got b_seen=%b early=%0d granted=%b required 1 0 1",
                            b_seen, early, d_arready);
      end
      @(posedge clk); #1 d_arvalid = 0;
      wait_done(base + 2, "wr_rd");
   endtask

   task automatic test_reset_mid();
      int base;
      reset_dut();
      r_wait = 5;
      exp_q.push_back('{kind: 0, addr: 32'h80000020, data: mem_rd(32'h80000020), strb: 8'h0});
      i_araddr = 32'h80000020; i_arvalid = 1;
      @(posedge clk); #1 i_arvalid = 0;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({m_rready, m_rvalid} !== 2'b10) begin
         errors++; $display("FAIL mid_in_ir got rready/rvalid=%b required 10", {m_rready, m_rvalid});
      end
      #1 rst = 1;
      #1;
      checks++;
      if ({i_arready, d_arready, d_awready, d_wready, m_arvalid, m_awvalid, m_wvalid,
           m_rready, m_bready, i_rvalid, d_rvalid, d_bvalid} !== 12'h0 ||
          m_araddr !== '0 || i_rdata !== '0) begin
         errors++; $display("FAIL mid_reset_outputs got rready=%b arv=%b required all 0", m_rready, m_arvalid);
      end
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 0;
      base = done_cnt; r_wait = 1;
      exp_q.push_back('{kind: 1, addr: 32'h80003000, data: mem_rd(32'h80003000), strb: 8'h0});
      d_read_wait(32'h80003000);
      checks++;
      if (done_cnt - base != 1) begin
         errors++; $display("FAIL mid_after_reset got %0d responses required 1", done_cnt - base);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_read();
      test_simultaneous();
      test_contention();
      test_write();
      test_write_then_read();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_22051086_axi_arbiter.md
# ysyx_22051086_axi_arbiter

Two-master to one-slave bus arbiter between the pipeline's instruction cache and data cache and the single external AXI4-Lite memory port. It takes ICACHE line-fill reads and DCACHE reads/writes, grants one transaction at a time, and routes the response back to the requester. Only one transaction is outstanding at any time, so a cache miss in IF and one in LS are serialized without reordering.

## Interface
- ADDR_W, 32, address width on all channels
- DATA_W, 64, data width; write strobe width is DATA_W/8
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- i_araddr / i_arvalid / i_arready  in/in/out  ADDR_W/1/1  ICACHE read address channel
- i_rdata / i_rresp / i_rvalid / i_rready  out/out/out/in  DATA_W/2/1/1  ICACHE read data channel
- d_araddr / d_arvalid / d_arready  in/in/out  ADDR_W/1/1  DCACHE read address channel
- d_rdata / d_rresp / d_rvalid / d_rready  out/out/out/in  DATA_W/2/1/1  DCACHE read data channel
- d_awaddr / d_awvalid / d_awready  in/in/out  ADDR_W/1/1  DCACHE write address channel
- d_wdata / d_wstrb / d_wvalid / d_wready  in/in/in/out  DATA_W/8/1/1  DCACHE write data channel
- d_bresp / d_bvalid / d_bready  out/out/in  2/1/1  DCACHE write response channel
- m_ar*, m_r*, m_aw*, m_w*, m_b*  mirror of the above toward memory (directions reversed)

## Operation
- States: IDLE, I_AR, I_R, D_AR, D_R, D_W, D_B.
- IDLE arbitration, evaluated each cycle:
  - D write request is d_awvalid && d_wvalid.
  - D write beats D read; within the D master, a write always precedes a read.
  - I read vs. any D request uses round-robin. A 1-bit last_grant (reset 0 = I) favours the master not granted last. Grant updates last_grant.
  - No request: stay IDLE.
- Address latched into arb_addr when granted; write data and strobe latched too. Master's valid must stay high until its ready (AXI rule). The arbiter asserts i_arready/d_arready/d_awready/d_wready for exactly one cycle, the IDLE grant cycle.
- I_AR / D_AR: m_arvalid=1, m_araddr=arb_addr; on m_arready go to I_R / D_R.
- I_R / D_R: m_rready mirrors the granted master's rready. Its rvalid/rdata/rresp mirror m_r*; the other master sees rvalid=0. On m_rvalid && m_rready go to IDLE.
- D_W: m_awvalid and m_wvalid both start at 1. Each drops independently after its handshake, using aw_done/w_done flags. Move to D_B once both are done, including when both handshake in the same cycle.
- D_B: d_bvalid/d_bresp mirror m_b*; m_bready = d_bready. On the handshake go to IDLE.
- rresp/bresp are passed through unmodified. Errors do not change the FSM.

## Timing
- Reset: state=IDLE, last_grant=0, aw_done=w_done=0, all valid/ready outputs 0, address/data outputs 0.
- A reset mid-transaction aborts to IDLE asynchronously. Nothing is replayed.
- Request seen in cycle N (IDLE): ready pulse in N, m_arvalid/m_awvalid high from N+1 (registered).
- Response path is combinational: master rvalid in the same cycle as m_rvalid.
- Minimum read occupancy is 3 cycles (IDLE grant, AR, R). There is at least one IDLE cycle between back-to-back transactions.
- A request that arrives while busy waits. Its valid is held until it is granted in a later IDLE cycle.
- Write with m_awready and m_wready both high on the first D_W cycle: D_W lasts 1 cycle.

## Test plan
- Single I read: i_araddr=0x80000000, memory returns 0x00000013_00100093 after 2 wait cycles. Expect i_arready pulse in cycle 0 and m_arvalid in cycle 1. i_rdata matches; d_rvalid stays 0.
- Simultaneous I read (0x80000010) and D read (0x80001000) from reset: I is granted first (last_grant=0), then D. Exactly one m_ar handshake per transaction, in that order.
- Sustained contention: I and D both request continuously for 8 transactions. Grants alternate I,D,I,D…; neither master waits more than one transaction.
- D write 0xDEADBEEF_CAFEF00D, strb 0x0F, addr 0x80002000, with m_wready 2 cycles after m_awready. aw_done is held, and D_B is entered only after the w handshake. d_bresp=0 is returned.
- D write and D read pending together: the write completes (b handshake) before m_arvalid rises for the read.
- Assert rst during I_R with m_rvalid low. All outputs are 0 immediately; after release, a new D read is granted normally.
